// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the iterative divider datapath.
package fpdiv_pkg;

   localparam int unsigned DefaultWidth = 32;

   // Fill bit for the quotient reported on divide-by-zero (all ones).
   localparam logic DbzFill = 1'b1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} div_state_e;

   // Carry-merge cell on {generate, propagate} pairs; hi is the more significant span.
   function automatic logic [1:0] pg_merge(input logic [1:0] hi, input logic [1:0] lo);
      return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
   endfunction

endpackage

// File: rtl/seqdiv32_if.sv
// Operand/result handshake bundle for seqdiv32.
interface seqdiv32_if import fpdiv_pkg::*; #(
   parameter int unsigned WIDTH = DefaultWidth
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/prefix_addsub.sv
// N-bit Kogge-Stone adder/subtractor; cin=1 inverts b so the result is a - b.
module prefix_addsub import fpdiv_pkg::*; #(
   parameter int unsigned N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int Levels = $clog2(N);

   logic [N-1:0] b_eff;
   logic [N-1:0] p_bit;
   logic [N-1:0] g_lvl, p_lvl;
   logic [N-1:0] g_nxt, p_nxt;

   always_comb begin
      b_eff = b ^ {N{cin}};
      p_bit = a ^ b_eff;
      g_lvl = a & b_eff;
      p_lvl = p_bit;
      // Fold carry-in into bit 0 so every prefix span starts from the LSB.
      g_lvl[0] = g_lvl[0] | (p_bit[0] & cin);
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int lvl = 0; lvl < Levels; lvl++) begin
         g_nxt = g_lvl;
         p_nxt = p_lvl;
         for (int i = 0; i < int'(N); i++) begin
            if (i >= (1 << lvl)) begin
               {g_nxt[i], p_nxt[i]} = pg_merge({g_lvl[i], p_lvl[i]},
                                               {g_lvl[i - (1 << lvl)], p_lvl[i - (1 << lvl)]});
            end
         end
         g_lvl = g_nxt;
         p_lvl = p_nxt;
      end
      sum  = p_bit ^ {g_lvl[N-2:0], cin};
      cout = g_lvl[N-1];
   end

endmodule

// File: rtl/seqdiv32.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, valid/ready in and out.
module seqdiv32 import fpdiv_pkg::*; #(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input logic       clk,
   input logic       rst_n,
   seqdiv32_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH);

   div_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted, trial;
   logic             no_borrow;
   logic             accept, release_res;
   logic             unused_rem_msb;

   assign accept         = bus.in_valid && (state_q == StIdle);
   assign release_res    = bus.out_ready && (state_q == StDone);
   assign shifted        = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
   // The top remainder bit only absorbs the shift-in and is zero after every update.
   assign unused_rem_msb = rem_q[WIDTH];

   prefix_addsub #(
      .N(WIDTH + 1)
   ) u_addsub (
      .a   (shifted),
      .b   ({1'b0, divisor_q}),
      .cin (1'b1),
      .sum (trial),
      .cout(no_borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (bus.in_valid) state_d = (bus.divisor == '0) ? StDone : StCalc;
         StCalc: if (cnt_q == '0) state_d = StDone;
         StDone: if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.in_ready    = (state_q == StIdle);
      bus.out_valid   = (state_q == StDone);
      bus.quotient    = q_q;
      bus.remainder   = rem_q[WIDTH-1:0];
      bus.div_by_zero = dbz_q;
   end

   always_comb begin
      cnt_d     = cnt_q;
      q_d       = q_q;
      rem_d     = rem_q;
      divisor_d = divisor_q;
      dbz_d     = dbz_q;
      if (accept) begin
         divisor_d = bus.divisor;
         if (bus.divisor == '0) begin
            q_d   = {WIDTH{DbzFill}};
            rem_d = {1'b0, bus.dividend};
            dbz_d = 1'b1;
         end else begin
            q_d   = bus.dividend;
            rem_d = '0;
            cnt_d = CntW'(WIDTH - 1);
         end
      end else if (state_q == StCalc) begin
         rem_d = no_borrow ? trial : shifted;
         q_d   = {q_q[WIDTH-2:0], no_borrow};
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end else if (release_res) begin
         dbz_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         q_q       <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         dbz_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         rem_q     <= rem_d;
         divisor_q <= divisor_d;
         dbz_q     <= dbz_d;
      end
   end

endmodule

// File: tb/tb_seqdiv32.sv
// Directed self-checking bench for seqdiv32 with a short randomised tail.
module tb_seqdiv32;
   import fpdiv_pkg::*;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_fail = 0;

   seqdiv32_if #(.WIDTH(W)) bus ();

   seqdiv32 #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one operand pair and returns cycles from accept to out_valid (accept cycle = 0).
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      int waited = 0;
      while (!bus.in_ready && waited < 100) begin
         step();
         waited++;
      end
      check("in_ready_before_issue", W'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 3 * W) begin
         step();
         lat++;
      end
   endtask

   task automatic take();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int elat, input int bp);
      int lat;
      logic [63:0] recon;
      issue(a, b, lat);
      check({tag, "_latency"}, W'(lat), W'(elat));
      for (int k = 0; k <= bp; k++) begin
         check({tag, "_quotient"}, bus.quotient, eq);
         check({tag, "_remainder"}, bus.remainder, er);
         check({tag, "_dbz"}, W'(bus.div_by_zero), W'(edz));
         check({tag, "_in_ready_low"}, W'(bus.in_ready), 0);
         if (k < bp) step();
      end
      if (b != '0) begin
         recon = 64'(bus.quotient) * 64'(b) + 64'(bus.remainder);
         check({tag, "_identity"}, recon[W-1:0], a);
      end
      take();
      check({tag, "_in_ready_back"}, W'(bus.in_ready), 1);
      check({tag, "_out_valid_drop"}, W'(bus.out_valid), 0);
   endtask

   initial begin
      int lat;
      logic [W-1:0] ra, rb, rq, rr;
      logic rdz;

      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b0;
      #2;
      check("rst_in_ready", W'(bus.in_ready), 1);
      check("rst_out_valid", W'(bus.out_valid), 0);
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_dbz", W'(bus.div_by_zero), 0);
      #10;
      rst_n = 1'b1;
      step();

      run_op("d100_7", 100, 7, 14, 2, 1'b0, W + 1, 0);
      run_op("dmax_1", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1'b0, W + 1, 0);
      run_op("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1'b0, W + 1, 0);
      run_op("d3_10", 3, 10, 0, 3, 1'b0, W + 1, 0);
      run_op("d0_5", 0, 5, 0, 0, 1'b0, W + 1, 0);
      run_op("d5_0", 5, 0, 32'hFFFF_FFFF, 5, 1'b1, 1, 2);
      run_op("d9_3", 9, 3, 3, 0, 1'b0, W + 1, 0);

      // 1000/9 with a competing in_valid held through CALC and DONE, then back-pressure.
      bus.in_valid = 1'b1;
      bus.dividend = 1000;
      bus.divisor  = 9;
      step();
      bus.dividend = 55;
      bus.divisor  = 0;
      lat = 1;
      while (!bus.out_valid && lat < 3 * W) begin
         step();
         lat++;
      end
      check("bp_latency", W'(lat), W + 1);
      for (int k = 0; k <= 5; k++) begin
         check("bp_quotient", bus.quotient, 111);
         check("bp_remainder", bus.remainder, 1);
         check("bp_dbz", W'(bus.div_by_zero), 0);
         check("bp_in_ready_low", W'(bus.in_ready), 0);
         if (k < 5) step();
      end
      bus.in_valid = 1'b0;
      take();
      check("bp_in_ready_back", W'(bus.in_ready), 1);
      check("bp_out_valid_drop", W'(bus.out_valid), 0);

      // Reset in the middle of a calculation discards it.
      bus.in_valid = 1'b1;
      bus.dividend = 1000;
      bus.divisor  = 9;
      step();
      bus.in_valid = 1'b0;
      repeat (9) step();
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", W'(bus.out_valid), 0);
      check("midrst_in_ready", W'(bus.in_ready), 1);
      check("midrst_quotient", bus.quotient, 0);
      check("midrst_remainder", bus.remainder, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      check("midrst_no_result", W'(bus.out_valid), 0);
      run_op("d77_8", 77, 8, 9, 5, 1'b0, W + 1, 0);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         if (i % 5 == 0) rb = 0;
         else if (i % 3 == 0) rb = $urandom_range(1, 15);
         else rb = $urandom >> $urandom_range(0, 31);
         if (rb == '0) begin
            rq  = '1;
            rr  = ra;
            rdz = 1'b1;
         end else begin
            rq  = ra / rb;
            rr  = ra % rb;
            rdz = 1'b0;
         end
         run_op("rand", ra, rb, rq, rr, rdz, rdz ? 1 : W + 1, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/seqdiv32.md
# seqdiv32

Iterative unsigned restoring divider for the pipelined FP datapath; it is the inverse of the multiplier and consumes mantissas or integers. Each iteration does one trial subtraction in a parallel-prefix add/sub slice with carry-in = 1 meaning subtract. It produces one quotient bit per cycle and uses a valid/ready handshake on both input and output.

## Interface
- WIDTH, 32, operand/quotient/remainder width (≥4)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept (high only in IDLE)
- dividend  in  WIDTH  unsigned dividend
- divisor  in  WIDTH  unsigned divisor
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- quotient  out  WIDTH  floor(dividend/divisor)
- remainder  out  WIDTH  dividend mod divisor
- div_by_zero  out  1  divisor was zero for this result

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch the divisor.
  - Divisor ≠0: q_reg←dividend, rem_reg (WIDTH+1 bits)←0, cnt←WIDTH-1, go to CALC.
  - Divisor =0: quotient←all ones, remainder←dividend, div_by_zero←1, go straight to DONE.
- CALC, one iteration per cycle:
  - shifted = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]}.
  - trial = shifted − {0,divisor}, computed as shifted + ~{0,divisor} + 1 in the WIDTH+1-bit prefix slice.
  - Carry-out =1 (no borrow): rem_reg←trial, q_reg←{q_reg[WIDTH-2:0],1}.
  - Carry-out =0: rem_reg←shifted, q_reg←{q_reg[WIDTH-2:0],0}.
  - cnt decrements. The iteration that runs with cnt==0 moves the FSM to DONE.
- DONE: out_valid=1. quotient=q_reg, remainder=rem_reg[WIDTH-1:0], div_by_zero=flag. On out_valid&out_ready, go to IDLE and clear div_by_zero.
- in_valid is ignored outside IDLE; no operand is queued.
- Outputs hold stable while out_valid=1 and out_ready=0.
- rem_reg[WIDTH] is always 0 after an update. The extra bit exists only to absorb the shift-in.

## Timing
- Accept edge at cycle T. CALC occupies cycles T+1..T+WIDTH. out_valid rises at T+WIDTH+1 (33 cycles for WIDTH=32).
- Divide-by-zero: out_valid at T+1.
- in_ready comes back the cycle after the output handshake. Minimum issue interval is WIDTH+2 cycles.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, cnt=0.
- Reset asserted mid-CALC or mid-DONE: immediate return to the reset values; the in-flight result is discarded and no out_valid is produced for it.
- in_ready and out_valid are never both 1.
- The trial subtract is combinational within one cycle. No multicycle path.

## Structure
- Shared package `fpdiv_pkg`: state enum (IDLE/CALC/DONE), default WIDTH, the all-ones quotient constant for divide-by-zero.
- Sub-module `prefix_addsub`: parameterised N-bit parallel-prefix adder with carry-in. Carry-in=1 inverts b and adds one, so it performs subtraction. Outputs sum and carry-out. It is built from the team's propagate/generate and carry-merge cells with log2(N) merge levels. Instantiate it with N=WIDTH+1.
- The divider is FSM + counter + q/rem shift registers + one `prefix_addsub`.

## Test plan
- 100/7, out_ready=1 → out_valid at T+33, quotient=14, remainder=2, div_by_zero=0; in_ready back at T+34.
- 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0. Then 0xFFFFFFFF/0xFFFFFFFF → quotient=1, remainder=0.
- 3/10 → quotient=0, remainder=3. Then 0/5 → quotient=0, remainder=0.
- 5/0 → out_valid at T+1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. The next op 9/3 gives div_by_zero=0, quotient=3.
- 1000/9 with out_ready low for 5 cycles after out_valid → outputs stay 111/1 until the handshake. in_valid pulsed during CALC and DONE is ignored.
- rst_n low at T+10 of 1000/9 → out_valid=0 and in_ready=1 immediately. A following 77/8 completes with 9/5 at exactly WIDTH+1 cycles.
- Random 10k ops with back-pressure → checked against a reference model of floor division and mod; quotient·divisor+remainder==dividend.
